// File: rtl/imem_loader_if.sv
// Instruction-field handshake and byte-write bus between a host loader and
// the instruction memory write port.
interface imem_loader_if #(
    parameter int ADDR_W = 7
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_opcode;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    // Loader side: consumes instruction fields, drives the memory write port.
    modport master (
        input  in_valid, in_opcode, in_rd, in_rs1, in_rs2,
        output in_ready, wr_en, wr_addr, wr_data
    );

    // Host/memory side.
    modport slave (
        output in_valid, in_opcode, in_rd, in_rs1, in_rs2,
        input  in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction encoder/loader: accepts decoded fields and writes each
// instruction as four bytes {opcode, rd, rs1, rs2} into instruction memory.
module imem_loader #(
    parameter int ADDR_W     = 7,
    parameter int MEM_BYTES  = 128,
    parameter int BASE_ADDR  = 0,
    parameter int MAX_OPCODE = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    imem_loader_if.master bus,
    output logic          busy,
    output logic          done,
    output logic          full,
    output logic          err_opcode,
    output logic [5:0]    instr_count
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        W0   = 3'd1,
        W1   = 3'd2,
        W2   = 3'd3,
        W3   = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] BASE_C   = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   END_C    = (ADDR_W+1)'(MEM_BYTES);
    localparam logic [3:0]        MAX_OP_C = 4'(MAX_OPCODE);

    state_t            state_r, state_s;
    logic [3:0]        opcode_r;
    logic [4:0]        rd_r, rs1_r, rs2_r;
    logic [ADDR_W-1:0] ptr_r, ptr_s;
    logic [ADDR_W:0]   ptr_inc_s;
    logic              full_r, full_s;
    logic              err_r, err_s;
    logic [5:0]        count_r, count_s;
    logic              wr_en_r, wr_en_s;
    logic [ADDR_W-1:0] wr_addr_r, wr_addr_s;
    logic [7:0]        wr_data_r, wr_data_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic              ready_s, accept_s, legal_s;

    function automatic logic opcode_legal(input logic [3:0] op);
        return (op != 4'd0) && (op <= MAX_OP_C);
    endfunction

    assign ready_s   = (state_r == IDLE) && !full_r && !reset;
    assign accept_s  = bus.in_valid && ready_s;
    assign legal_s   = opcode_legal(bus.in_opcode);
    // One extra bit so the end-of-region test works even when ptr wraps to 0.
    assign ptr_inc_s = {1'b0, ptr_r} + (ADDR_W+1)'(4);

    // Next-state: one W state per clock, clear always returns to IDLE.
    always_comb begin
        state_s = state_r;
        if (clear) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s && legal_s) begin
                        state_s = W0;
                    end else begin
                        state_s = IDLE;
                    end
                end
                W0:      state_s = W1;
                W1:      state_s = W2;
                W2:      state_s = W3;
                W3:      state_s = IDLE;
                default: state_s = IDLE;
            endcase
        end
    end

    // Write-port values for the state being entered; W0 takes the live opcode.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = '0;
        wr_data_s = 8'h00;
        busy_s    = 1'b0;
        done_s    = 1'b0;
        case (state_s)
            W0: begin
                wr_en_s   = 1'b1;
                busy_s    = 1'b1;
                wr_addr_s = ptr_r;
                wr_data_s = {4'h0, bus.in_opcode};
            end
            W1: begin
                wr_en_s   = 1'b1;
                busy_s    = 1'b1;
                wr_addr_s = ptr_r + ADDR_W'(1);
                wr_data_s = {3'b000, rd_r};
            end
            W2: begin
                wr_en_s   = 1'b1;
                busy_s    = 1'b1;
                wr_addr_s = ptr_r + ADDR_W'(2);
                wr_data_s = {3'b000, rs1_r};
            end
            W3: begin
                wr_en_s   = 1'b1;
                busy_s    = 1'b1;
                done_s    = 1'b1;
                wr_addr_s = ptr_r + ADDR_W'(3);
                wr_data_s = {3'b000, rs2_r};
            end
            default: begin
                wr_en_s = 1'b0;
            end
        endcase
    end

    // Session bookkeeping: pointer, count, full and sticky opcode error.
    always_comb begin
        ptr_s   = ptr_r;
        count_s = count_r;
        full_s  = full_r;
        err_s   = err_r;
        if (clear) begin
            ptr_s   = BASE_C;
            count_s = 6'd0;
            full_s  = 1'b0;
            err_s   = 1'b0;
        end else if (state_r == W3) begin
            ptr_s   = ptr_inc_s[ADDR_W-1:0];
            count_s = count_r + 6'd1;
            full_s  = full_r || (ptr_inc_s >= END_C);
        end else if (accept_s && !legal_s) begin
            err_s = 1'b1;
        end else begin
            err_s = err_r;
        end
    end

    // State, holding and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            opcode_r  <= 4'h0;
            rd_r      <= 5'd0;
            rs1_r     <= 5'd0;
            rs2_r     <= 5'd0;
            ptr_r     <= BASE_C;
            count_r   <= 6'd0;
            full_r    <= 1'b0;
            err_r     <= 1'b0;
            wr_en_r   <= 1'b0;
            wr_addr_r <= '0;
            wr_data_r <= 8'h00;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                opcode_r <= bus.in_opcode;
                rd_r     <= bus.in_rd;
                rs1_r    <= bus.in_rs1;
                rs2_r    <= bus.in_rs2;
            end
            ptr_r     <= ptr_s;
            count_r   <= count_s;
            full_r    <= full_s;
            err_r     <= err_s;
            wr_en_r   <= wr_en_s;
            wr_addr_r <= wr_addr_s;
            wr_data_r <= wr_data_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
        end
    end

    assign bus.in_ready = ready_s;
    assign bus.wr_en    = wr_en_r;
    assign bus.wr_addr  = wr_addr_r;
    assign bus.wr_data  = wr_data_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign full         = full_r;
    assign err_opcode   = err_r;
    assign instr_count  = count_r;
endmodule

// File: tb/tb_imem_loader.sv
// Randomised bench for imem_loader: a behavioural model predicts every byte
// write (address, data, cycle, done) and the session status flags.
module tb_imem_loader;
    localparam int ADDR_W     = 7;
    localparam int MEM_BYTES  = 128;
    localparam int BASE_ADDR  = 0;
    localparam int MAX_OPCODE = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear;
    logic       busy, done, full, err_opcode;
    logic [5:0] instr_count;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(
        .ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES),
        .BASE_ADDR(BASE_ADDR), .MAX_OPCODE(MAX_OPCODE)
    ) dut (
        .clk(clk), .reset(reset), .clear(clear), .bus(bus),
        .busy(busy), .done(done), .full(full),
        .err_opcode(err_opcode), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
        int cyc;
        int dn;
    } wr_t;

    wr_t obs_q[$];
    wr_t exp_q[$];
    int  cyc        = 0;
    int  stray_done = 0;
    int  checks     = 0;
    int  errors     = 0;

    int ptr_m, count_m;
    bit full_m, err_m;

    // Memory-side monitor: records every byte the consumer would sample.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (bus.wr_en === 1'b1)
            obs_q.push_back('{int'(bus.wr_addr), int'(bus.wr_data), cyc, int'(done)});
        else if (done === 1'b1)
            stray_done = stray_done + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        ptr_m   = BASE_ADDR;
        count_m = 0;
        full_m  = 1'b0;
        err_m   = 1'b0;
    endfunction

    // Writes due after cycle c are abandoned by a clear/reset at that point.
    function automatic void prune(input int c);
        wr_t keep[$];
        foreach (exp_q[i]) if (exp_q[i].cyc <= c) keep.push_back(exp_q[i]);
        exp_q = keep;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         output int h);
        bit acc = 1'b0;
        bit exp_acc;
        int waited = 0;
        int b[4];
        bus.in_valid  = 1'b1;
        bus.in_opcode = op;
        bus.in_rd     = rd;
        bus.in_rs1    = rs1;
        bus.in_rs2    = rs2;
        while (!acc && waited < 10) begin
            if (bus.in_ready === 1'b1) acc = 1'b1;
            tick();
            waited++;
        end
        bus.in_valid = 1'b0;
        h = cyc;
        exp_acc = !full_m;
        check("accept", acc, exp_acc);
        if (exp_acc) begin
            if (op >= 1 && op <= MAX_OPCODE) begin
                b = '{int'(op), int'(rd), int'(rs1), int'(rs2)};
                for (int j = 0; j < 4; j++)
                    exp_q.push_back('{ptr_m + j, b[j], h + 1 + j, (j == 3) ? 1 : 0});
                ptr_m += 4;
                count_m++;
                if (ptr_m >= MEM_BYTES) begin
                    full_m = 1'b1;
                    ptr_m  = ptr_m % (1 << ADDR_W);
                end
            end else begin
                err_m = 1'b1;
            end
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        prune(cyc);
        model_reset();
    endtask

    task automatic drain_and_check(input string tag);
        repeat (6) tick();
        check({tag, ".nwr"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            check({tag, ".addr"}, obs_q[i].addr, exp_q[i].addr);
            check({tag, ".data"}, obs_q[i].data, exp_q[i].data);
            check({tag, ".cyc"},  obs_q[i].cyc,  exp_q[i].cyc);
            check({tag, ".done"}, obs_q[i].dn,   exp_q[i].dn);
        end
        obs_q.delete();
        exp_q.delete();
        check({tag, ".count"}, instr_count, count_m);
        check({tag, ".full"},  full, full_m);
        check({tag, ".err"},   err_opcode, err_m);
        check({tag, ".busy"},  busy, 1'b0);
        check({tag, ".ready"}, bus.in_ready, !full_m);
    endtask

    initial begin
        int h, hp;
        logic [7:0] prog_bytes [16];
        logic [3:0] op;

        reset = 1'b0; clear = 1'b0;
        bus.in_valid = 1'b0; bus.in_opcode = 4'h0;
        bus.in_rd = 5'd0; bus.in_rs1 = 5'd0; bus.in_rs2 = 5'd0;
        model_reset();

        #2 reset = 1'b1;
        #10;
        check("rst.wr_en",   bus.wr_en, 1'b0);
        check("rst.wr_addr", bus.wr_addr, 0);
        check("rst.wr_data", bus.wr_data, 0);
        check("rst.busy",    busy, 1'b0);
        check("rst.done",    done, 1'b0);
        check("rst.full",    full, 1'b0);
        check("rst.err",     err_opcode, 1'b0);
        check("rst.count",   instr_count, 0);
        check("rst.ready",   bus.in_ready, 1'b0);
        #1 reset = 1'b0;
        #1 check("rst.ready_after", bus.in_ready, 1'b1);
        tick();

        // Single MUL 3,2,1 with in_ready profile across the write cycles.
        issue(4'd1, 5'd3, 5'd2, 5'd1, h);
        check("single.ready_w0", bus.in_ready, 1'b0);
        for (int j = 1; j <= 4; j++) begin
            tick();
            check("single.ready", bus.in_ready, (j == 4) ? 1'b1 : 1'b0);
        end
        drain_and_check("single");

        // Four-instruction program, in_valid held between instructions.
        prog_bytes = '{8'h01, 8'h03, 8'h02, 8'h01, 8'h02, 8'h06, 8'h05, 8'h04,
                       8'h03, 8'h09, 8'h08, 8'h07, 8'h04, 8'h0D, 8'h0B, 8'h0A};
        do_clear();
        issue(4'd1, 5'd3, 5'd2, 5'd1, hp);
        issue(4'd2, 5'd6, 5'd5, 5'd4, h);   check("prog.gap", h - hp, 5); hp = h;
        issue(4'd3, 5'd9, 5'd8, 5'd7, h);   check("prog.gap", h - hp, 5); hp = h;
        issue(4'd4, 5'd13, 5'd11, 5'd10, h); check("prog.gap", h - hp, 5);
        repeat (6) tick();
        check("prog.nwr", obs_q.size(), 16);
        for (int i = 0; i < 16 && i < obs_q.size(); i++) begin
            check("prog.byte", obs_q[i].data, prog_bytes[i]);
            check("prog.addr", obs_q[i].addr, i);
        end
        drain_and_check("prog");

        // Illegal opcodes 0 and 5, then an XOR at the unchanged pointer.
        issue(4'd0, 5'd1, 5'd1, 5'd1, hp);
        issue(4'd5, 5'd2, 5'd2, 5'd2, h);
        check("illegal.back_to_back", h - hp, 1);
        check("illegal.err", err_opcode, 1'b1);
        issue(4'd3, 5'd17, 5'd18, 5'd19, h);
        drain_and_check("illegal");

        // Fill the region, try a 33rd instruction, then clear and restart.
        do_clear();
        for (int i = 0; i < 32; i++)
            issue(4'($urandom_range(1, 4)), 5'($urandom), 5'($urandom), 5'($urandom), h);
        drain_and_check("fill");
        issue(4'd2, 5'd1, 5'd2, 5'd3, h);
        drain_and_check("overflow");
        do_clear();
        check("clear.full", full, 1'b0);
        check("clear.count", instr_count, 0);
        issue(4'd4, 5'd7, 5'd8, 5'd9, h);
        drain_and_check("restart");

        // clear during W1.
        issue(4'd2, 5'd4, 5'd5, 5'd6, h);
        tick();
        do_clear();
        drain_and_check("clear_w1");

        // Asynchronous reset pulse in the middle of W2.
        issue(4'd4, 5'd21, 5'd22, 5'd23, h);
        tick();
        tick();
        #2 reset = 1'b1;
        #1;
        check("arst.wr_en", bus.wr_en, 1'b0);
        check("arst.busy",  busy, 1'b0);
        check("arst.done",  done, 1'b0);
        check("arst.ready", bus.in_ready, 1'b0);
        #1 reset = 1'b0;
        #1 check("arst.ready_after", bus.in_ready, 1'b1);
        prune(cyc);
        model_reset();
        tick();
        issue(4'd1, 5'd30, 5'd29, 5'd28, h);
        drain_and_check("arst");

        // Randomised traffic with illegal opcodes, idle gaps and stray clears.
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 9) < 8)
                op = 4'($urandom_range(1, 4));
            else if ($urandom_range(0, 1) == 0)
                op = 4'd0;
            else
                op = 4'($urandom_range(5, 15));
            issue(op, 5'($urandom), 5'($urandom), 5'($urandom), h);
            if ($urandom_range(0, 7) == 0) begin
                repeat ($urandom_range(0, 5)) tick();
                do_clear();
            end
            repeat ($urandom_range(0, 3)) tick();
            if (it % 10 == 9) drain_and_check("rand");
        end
        drain_and_check("rand_end");

        check("stray_done", stray_done, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
